// File: rtl/window3x3_gen.sv
// Raster-scan 3x3 window generator: two line buffers plus a 3-column shift register.
// rst_n must be deasserted synchronously to clk by the reset generator.
module window3x3_gen #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_pixel,
  input  logic       in_sof,
  output logic       out_valid,
  output logic [7:0] p00,
  output logic [7:0] p01,
  output logic [7:0] p02,
  output logic [7:0] p10,
  output logic [7:0] p11,
  output logic [7:0] p12,
  output logic [7:0] p20,
  output logic [7:0] p21,
  output logic [7:0] p22,
  output logic       out_eof
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);
  localparam logic [XW-1:0] XTwo  = XW'(2);
  localparam logic [YW-1:0] YTwo  = YW'(2);

  typedef enum logic [0:0] {StWaitSof, StActive} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d, cur_x;
  logic [YW-1:0] y_q, y_d, cur_y;
  logic          accept;
  logic [7:0]    up0, up1;

  // lb0 holds line y-1, lb1 holds line y-2
  logic [7:0] lb0 [IMG_W];
  logic [7:0] lb1 [IMG_W];

  always_comb begin
    accept  = 1'b0;
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      StWaitSof: accept = in_valid && in_sof;
      StActive:  accept = in_valid;
      default:   accept = 1'b0;
    endcase
    // A start-of-frame pixel always lands at (0,0), aborting any frame in flight
    cur_x = (in_valid && in_sof) ? '0 : x_q;
    cur_y = (in_valid && in_sof) ? '0 : y_q;
    if (accept) begin
      state_d = StActive;
      if (cur_x == XLast) begin
        x_d = '0;
        if (cur_y == YLast) begin
          y_d     = '0;
          state_d = StWaitSof;
        end else begin
          y_d = cur_y + YW'(1);
        end
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWaitSof;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign up0 = lb0[cur_x];
  assign up1 = lb1[cur_x];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[cur_x] <= up0;
      lb0[cur_x] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      p00 <= '0; p01 <= '0; p02 <= '0;
      p10 <= '0; p11 <= '0; p12 <= '0;
      p20 <= '0; p21 <= '0; p22 <= '0;
    end else begin
      // Row gating on y >= 2 keeps stale line-buffer data out of every window
      out_valid <= accept && (cur_x >= XTwo) && (cur_y >= YTwo);
      out_eof   <= accept && (cur_x == XLast) && (cur_y == YLast);
      if (accept) begin
        p00 <= p01; p01 <= p02; p02 <= up1;
        p10 <= p11; p11 <= p12; p12 <= up0;
        p20 <= p21; p21 <= p22; p22 <= in_pixel;
      end
    end
  end

endmodule
